pipelined_control_unit: RTL and testbench
=========================================

# pipelined_control_unit

Control unit for the 5-stage pipelined RV32I core, replacing the single-cycle control path. Decodes the instruction held in IF/ID and carries its control word through internal ID/EX, EX/MEM and MEM/WB control registers. Resolves branches in EX. Generates the load-use/RAW stall, the branch flush and the EX-stage operand-forwarding selects. A parameter selects between a forwarding pipeline and a stall-only pipeline.

## Interface
- WIDTH, 32: instruction width; only bits [31:0] are decoded.
- FORWARDING, 1: 1 = forwarding plus load-use stall; 0 = no forwarding, stall on every RAW hazard.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- inst_id  in  WIDTH  instruction currently in IF/ID.
- zero, less_signed, less_unsigned  in  1 each  EX-stage ALU comparison flags for the instruction in ID/EX.
- alu_src_ex  out  1  EX operand-B select (1 = immediate).
- alu_ctrl_ex  out  4  EX ALU operation.
- mem_write_mem  out  1  data-memory write strobe, MEM stage.
- reg_write_wb  out  1  register-file write enable, WB stage.
- mem_to_reg_wb  out  1  WB source select (1 = memory).
- rd_wb  out  5  register-file write address.
- pc_sel  out  1  1 = PC loads branch target.
- pc_write, if_id_write  out  1 each  0 = hold PC / IF/ID.
- if_id_flush  out  1  1 = IF/ID loads a NOP next edge.
- forward_a, forward_b  out  2 each  EX operand selects: 00 regfile, 10 EX/MEM result, 01 MEM/WB result.

## Operation
- Supported opcodes:
  - 0110011 (R): reg_write=1, uses rs1 and rs2.
  - 0010011 (I-ALU): reg_write=1, alu_src=1, uses rs1.
  - 0000011 (load): reg_write=1, alu_src=1, mem_to_reg=1, uses rs1.
  - 0100011 (store): mem_write=1, alu_src=1, uses rs1 and rs2.
  - 1100011 (branch): branch=1, uses rs1 and rs2.
  - Any other opcode decodes as a bubble (all controls 0).
- alu_ctrl encoding:
  - R-type: {func7[5], func3}.
  - I-ALU: {0, func3}, except func3=101 gives {func7[5], 101}.
  - load/store: 0000 (ADD).
  - branch: 1000 (SUB).
- ID/EX register holds {reg_write, mem_write, mem_to_reg, alu_src, alu_ctrl, branch, func3, rs1, rs2, rd, is_load}. EX/MEM holds {reg_write, mem_write, mem_to_reg, rd}. MEM/WB holds {reg_write, mem_to_reg, rd}.
- Branch resolution (combinational from ID/EX):
  - pc_sel = branch AND condition selected by func3: 000 zero, 001 !zero, 100 less_signed, 101 !less_signed, 110 less_unsigned, 111 !less_unsigned.
  - Other func3 values give pc_sel=0.
- Taken branch: if_id_flush=1 and ID/EX loads a bubble next edge. This costs 2 bubbles.
- A hazard exists only on a used source with nonzero register number matching a producer whose reg_write=1.
  - FORWARDING=1: stall when the ID/EX instruction is a load and its rd matches a used ID source.
  - FORWARDING=0: stall when ID/EX rd or EX/MEM rd matches a used ID source.
  - The register file is write-first, so MEM/WB needs no stall.
- Stall effect: pc_write=0, if_id_write=0, ID/EX loads a bubble.
- Forwarding (FORWARDING=1), per operand:
  - 10 if EX/MEM reg_write and EX/MEM rd = ID/EX rs (nonzero).
  - Otherwise 01 if the same test holds for MEM/WB.
  - Otherwise 00.
  - EX/MEM takes priority over MEM/WB.
- FORWARDING=0: forward_a = forward_b = 00 always.
- Branch taken and stall in the same cycle: the flush wins. pc_write=1, if_id_write=1, if_id_flush=1, ID/EX loads a bubble.

## Timing
- Decode, hazard, forwarding and pc_sel logic is combinational.
- Control-word latency relative to the cycle an instruction sits in IF/ID:
  - EX outputs: +1 cycle.
  - mem_write_mem: +2 cycles.
  - reg_write_wb, mem_to_reg_wb, rd_wb: +3 cycles.
- A stall lasts exactly as long as the hazard condition holds, re-evaluated every cycle. A load-use stall is 1 cycle.
- Reset clears all three control registers to zero. With registers cleared, every registered output is 0.
  - Combinational outputs during and after reset: pc_sel=0, if_id_flush=0, forward=00, pc_write=1, if_id_write=1.
- Reset asserted mid-stall or mid-flush discards all in-flight control on the next edge.

## Test plan
- add x3,x1,x2 (0x002081B3) in ID for one cycle, then NOPs: next cycle alu_ctrl_ex=0000 and alu_src_ex=0. Three cycles later reg_write_wb=1, rd_wb=3, mem_to_reg_wb=0.
- 0x002081B3 then sub x7,x3,x1 (0x401183B3), FORWARDING=1: while the sub is in EX, alu_ctrl_ex=1000, forward_a=10, forward_b=00, no stall.
- lw x5,0(x1) (0x0000A283) then add x6,x5,x5 (0x00528333): exactly one cycle of pc_write=0, if_id_write=0. The bubble shows reg_write_wb=0 in its WB slot. The add then sees forward_a=forward_b=01.
- Same pair with FORWARDING=0: 2 stall cycles, forward outputs stay 00.
- beq x0,x0,8 (0x00000463) with zero=1 in EX: pc_sel=1 and if_id_flush=1 that cycle. The next two WB slots have reg_write_wb=0. Repeating with zero=0 gives pc_sel=0 and no flush.
- Assert reset during a load-use stall: next cycle all registered outputs are 0 and pc_write=1.

Source files
------------

// File: rtl/pipelined_control_unit_if.sv
// Bus between the pipeline datapath and its control unit: the IF/ID instruction,
// the EX comparison flags, and every control word and hazard select coming back.
interface pipelined_control_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] inst_id;
    logic             zero;
    logic             less_signed;
    logic             less_unsigned;
    logic             alu_src_ex;
    logic [3:0]       alu_ctrl_ex;
    logic             mem_write_mem;
    logic             reg_write_wb;
    logic             mem_to_reg_wb;
    logic [4:0]       rd_wb;
    logic             pc_sel;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic [1:0]       forward_a;
    logic [1:0]       forward_b;

    modport master (
        output inst_id, zero, less_signed, less_unsigned,
        input  alu_src_ex, alu_ctrl_ex, mem_write_mem, reg_write_wb, mem_to_reg_wb,
               rd_wb, pc_sel, pc_write, if_id_write, if_id_flush, forward_a, forward_b
    );

    modport slave (
        input  inst_id, zero, less_signed, less_unsigned,
        output alu_src_ex, alu_ctrl_ex, mem_write_mem, reg_write_wb, mem_to_reg_wb,
               rd_wb, pc_sel, pc_write, if_id_write, if_id_flush, forward_a, forward_b
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// Control path for the 5-stage RV32I pipeline: decode, branch resolution in EX,
// RAW/load-use stall, branch flush and EX operand forwarding selects.
module pipelined_control_unit #(
    parameter int WIDTH      = 32,
    parameter bit FORWARDING = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    pipelined_control_unit_if.slave bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [3:0] alu_ctrl;
        logic       branch;
        logic [2:0] func3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       is_load;
    } id_ex_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic [4:0] rd;
    } ex_mem_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic [4:0] rd;
    } mem_wb_t;

    id_ex_t  dec, id_ex_d, id_ex_q;
    ex_mem_t ex_mem_d, ex_mem_q;
    mem_wb_t mem_wb_d, mem_wb_q;
    logic    branch_cond, branch_taken, stall_raw, stall;
    logic [1:0] fwd_a, fwd_b;
    logic    inst_unused;

    assign inst_unused = ^{bus.inst_id[WIDTH-1:31], bus.inst_id[29:25]};

    function automatic logic src_hit(input logic [4:0] src, input logic wr, input logic [4:0] dst);
        return wr && (src != 5'd0) && (src == dst);
    endfunction

    // Source fields are only kept for operands the instruction really reads,
    // so a zero register number doubles as "operand unused" in the hazard logic.
    always_comb begin
        dec = '0;
        case (bus.inst_id[6:0])
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.alu_ctrl  = {bus.inst_id[30], bus.inst_id[14:12]};
                dec.rs1       = bus.inst_id[19:15];
                dec.rs2       = bus.inst_id[24:20];
                dec.rd        = bus.inst_id[11:7];
            end
            OP_I: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = (bus.inst_id[14:12] == 3'b101) ? {bus.inst_id[30], 3'b101}
                                                               : {1'b0, bus.inst_id[14:12]};
                dec.rs1       = bus.inst_id[19:15];
                dec.rd        = bus.inst_id[11:7];
            end
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.is_load    = 1'b1;
                dec.rs1        = bus.inst_id[19:15];
                dec.rd         = bus.inst_id[11:7];
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.rs1       = bus.inst_id[19:15];
                dec.rs2       = bus.inst_id[24:20];
            end
            OP_BRANCH: begin
                dec.branch   = 1'b1;
                dec.alu_ctrl = 4'b1000;
                dec.func3    = bus.inst_id[14:12];
                dec.rs1      = bus.inst_id[19:15];
                dec.rs2      = bus.inst_id[24:20];
            end
            default: dec = '0;
        endcase
    end

    always_comb begin
        case (id_ex_q.func3)
            3'b000:  branch_cond = bus.zero;
            3'b001:  branch_cond = !bus.zero;
            3'b100:  branch_cond = bus.less_signed;
            3'b101:  branch_cond = !bus.less_signed;
            3'b110:  branch_cond = bus.less_unsigned;
            3'b111:  branch_cond = !bus.less_unsigned;
            default: branch_cond = 1'b0;
        endcase
        branch_taken = id_ex_q.branch && branch_cond && !reset;

        if (FORWARDING) begin
            stall_raw = id_ex_q.is_load &&
                        (src_hit(dec.rs1, id_ex_q.reg_write, id_ex_q.rd) ||
                         src_hit(dec.rs2, id_ex_q.reg_write, id_ex_q.rd));
        end else begin
            stall_raw = src_hit(dec.rs1, id_ex_q.reg_write, id_ex_q.rd) ||
                        src_hit(dec.rs2, id_ex_q.reg_write, id_ex_q.rd) ||
                        src_hit(dec.rs1, ex_mem_q.reg_write, ex_mem_q.rd) ||
                        src_hit(dec.rs2, ex_mem_q.reg_write, ex_mem_q.rd);
        end
        stall = stall_raw && !reset;

        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (FORWARDING && !reset) begin
            if (src_hit(id_ex_q.rs1, ex_mem_q.reg_write, ex_mem_q.rd))      fwd_a = 2'b10;
            else if (src_hit(id_ex_q.rs1, mem_wb_q.reg_write, mem_wb_q.rd)) fwd_a = 2'b01;
            if (src_hit(id_ex_q.rs2, ex_mem_q.reg_write, ex_mem_q.rd))      fwd_b = 2'b10;
            else if (src_hit(id_ex_q.rs2, mem_wb_q.reg_write, mem_wb_q.rd)) fwd_b = 2'b01;
        end
    end

    always_comb begin
        id_ex_d             = (branch_taken || stall) ? '0 : dec;
        ex_mem_d.reg_write  = id_ex_q.reg_write;
        ex_mem_d.mem_write  = id_ex_q.mem_write;
        ex_mem_d.mem_to_reg = id_ex_q.mem_to_reg;
        ex_mem_d.rd         = id_ex_q.rd;
        mem_wb_d.reg_write  = ex_mem_q.reg_write;
        mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
        mem_wb_d.rd         = ex_mem_q.rd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    // A taken branch overrides a simultaneous stall: the stalled instruction is squashed anyway.
    assign bus.pc_sel        = branch_taken;
    assign bus.if_id_flush   = branch_taken;
    assign bus.pc_write      = branch_taken || !stall;
    assign bus.if_id_write   = branch_taken || !stall;
    assign bus.forward_a     = fwd_a;
    assign bus.forward_b     = fwd_b;
    assign bus.alu_src_ex    = id_ex_q.alu_src;
    assign bus.alu_ctrl_ex   = id_ex_q.alu_ctrl;
    assign bus.mem_write_mem = ex_mem_q.mem_write;
    assign bus.reg_write_wb  = mem_wb_q.reg_write;
    assign bus.mem_to_reg_wb = mem_wb_q.mem_to_reg;
    assign bus.rd_wb         = mem_wb_q.rd;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: forwarding and stall-only instances run side by side
// against an instruction-level pipeline model, checked through a scoreboard queue.
module tb_pipelined_control_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        bit       writes;
        bit       is_load;
        bit       is_store;
        bit       is_branch;
        bit       alu_src;
        bit       uses1;
        bit       uses2;
        bit [3:0] alu_ctrl;
        bit [2:0] f3;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit [4:0] rd;
    } rec_t;

    typedef struct packed {
        bit       dut;
        bit       pc_sel;
        bit       pc_write;
        bit       if_id_write;
        bit       flush;
        bit [1:0] fa;
        bit [1:0] fb;
        bit       chk_fa;
        bit       chk_fb;
        bit       alu_src;
        bit [3:0] alu_ctrl;
        bit       mem_write;
        bit       rw;
        bit       m2r;
        bit [4:0] rd;
        bit       chk_rd;
    } exp_t;

    typedef struct packed {
        logic       pc_sel;
        logic       pc_write;
        logic       if_id_write;
        logic       flush;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       alu_src;
        logic [3:0] alu_ctrl;
        logic       mem_write;
        logic       rw;
        logic       m2r;
        logic [4:0] rd;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pipelined_control_unit_if #(.WIDTH(32)) bus0 ();
    pipelined_control_unit_if #(.WIDTH(32)) bus1 ();

    pipelined_control_unit #(.WIDTH(32), .FORWARDING(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    pipelined_control_unit #(.WIDTH(32), .FORWARDING(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    exp_t        sbq[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] cur [2];
    rec_t        h_ex [2];
    rec_t        h_mem [2];
    rec_t        h_wb [2];
    logic [31:0] prog0[$];
    logic [31:0] prog1[$];
    bit          rand_mode = 1'b0;
    bit          fz = 1'b0, fls = 1'b0, flu = 1'b0;

    function automatic rec_t decode(input logic [31:0] i);
        rec_t r;
        r     = '0;
        r.rs1 = i[19:15];
        r.rs2 = i[24:20];
        r.rd  = i[11:7];
        r.f3  = i[14:12];
        case (i[6:0])
            7'b0110011: begin r.writes = 1; r.uses1 = 1; r.uses2 = 1; r.alu_ctrl = {i[30], i[14:12]}; end
            7'b0010011: begin
                r.writes = 1; r.uses1 = 1; r.alu_src = 1;
                r.alu_ctrl = (i[14:12] == 3'd5) ? {i[30], 3'd5} : {1'b0, i[14:12]};
            end
            7'b0000011: begin r.writes = 1; r.uses1 = 1; r.alu_src = 1; r.is_load = 1; end
            7'b0100011: begin r.is_store = 1; r.uses1 = 1; r.uses2 = 1; r.alu_src = 1; end
            7'b1100011: begin r.is_branch = 1; r.uses1 = 1; r.uses2 = 1; r.alu_ctrl = 4'b1000; end
            default:    r = '0;
        endcase
        return r;
    endfunction

    function automatic bit hit(input bit uses, input bit [4:0] r, input rec_t p);
        return uses && (r != 5'd0) && p.writes && (p.rd == r);
    endfunction

    function automatic bit [1:0] fsel(input bit [4:0] r, input rec_t m, input rec_t w);
        if (r != 5'd0 && m.writes && m.rd == r) return 2'b10;
        if (r != 5'd0 && w.writes && w.rd == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit model_stall(input rec_t id, input rec_t ex, input rec_t mem, input bit fwd);
        if (fwd) return ex.is_load && (hit(id.uses1, id.rs1, ex) || hit(id.uses2, id.rs2, ex));
        return hit(id.uses1, id.rs1, ex) || hit(id.uses2, id.rs2, ex) ||
               hit(id.uses1, id.rs1, mem) || hit(id.uses2, id.rs2, mem);
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] op;
        case ($urandom_range(0, 5))
            0:       op = 7'b0110011;
            1:       op = 7'b0010011;
            2:       op = 7'b0000011;
            3:       op = 7'b0100011;
            4:       op = 7'b1100011;
            default: op = 7'b0110111;
        endcase
        return {7'($urandom), 2'b00, 3'($urandom_range(0, 7)), 2'b00, 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 2'b00, 3'($urandom_range(0, 7)), op};
    endfunction

    function automatic logic [31:0] fetch(input int d);
        if (d == 0 && prog0.size() > 0) return prog0.pop_front();
        if (d == 1 && prog1.size() > 0) return prog1.pop_front();
        return rand_mode ? rand_inst() : NOP;
    endfunction

    task automatic load(input logic [31:0] i);
        prog0.push_back(i);
        prog1.push_back(i);
    endtask

    task automatic chk(input string name, input bit d, input logic [7:0] act, input logic [7:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s dut%0d t=%0t: actual %0h required %0h", name, d, $time, act, req);
    endtask

    task automatic step(input bit rst, input bit check);
        rec_t id, ex, mem, wb;
        exp_t e;
        bit   taken, stall, fwd;
        @(posedge clk);
        #1;
        if (rand_mode) begin
            fz  = 1'($urandom_range(0, 1));
            fls = 1'($urandom_range(0, 1));
            flu = 1'($urandom_range(0, 1));
        end
        reset = rst;
        bus0.zero = fz; bus0.less_signed = fls; bus0.less_unsigned = flu;
        bus1.zero = fz; bus1.less_signed = fls; bus1.less_unsigned = flu;
        bus0.inst_id = cur[0];
        bus1.inst_id = cur[1];
        for (int d = 0; d < 2; d++) begin
            fwd = (d == 0);
            id  = decode(cur[d]);
            ex  = h_ex[d];
            mem = h_mem[d];
            wb  = h_wb[d];
            taken = 1'b0;
            if (ex.is_branch) begin
                case (ex.f3)
                    3'd0: taken = fz;
                    3'd1: taken = !fz;
                    3'd4: taken = fls;
                    3'd5: taken = !fls;
                    3'd6: taken = flu;
                    3'd7: taken = !flu;
                    default: taken = 1'b0;
                endcase
            end
            stall = model_stall(id, ex, mem, fwd);
            if (rst) begin taken = 1'b0; stall = 1'b0; end
            e             = '0;
            e.dut         = d[0];
            e.pc_sel      = taken;
            e.flush       = taken;
            e.pc_write    = taken || !stall;
            e.if_id_write = taken || !stall;
            if (fwd && !rst) begin
                e.fa = fsel(ex.rs1, mem, wb); e.chk_fa = ex.uses1;
                e.fb = fsel(ex.rs2, mem, wb); e.chk_fb = ex.uses2;
            end else begin
                e.chk_fa = 1'b1;
                e.chk_fb = 1'b1;
            end
            e.alu_src   = ex.alu_src;
            e.alu_ctrl  = ex.alu_ctrl;
            e.mem_write = mem.is_store;
            e.rw        = wb.writes;
            e.m2r       = wb.is_load;
            e.rd        = wb.rd;
            e.chk_rd    = wb.writes;
            if (check) sbq.push_back(e);
            if (rst) begin
                h_ex[d] = '0; h_mem[d] = '0; h_wb[d] = '0;
                cur[d] = fetch(d);
            end else begin
                h_wb[d]  = mem;
                h_mem[d] = ex;
                h_ex[d]  = (taken || stall) ? '0 : id;
                if (taken)       cur[d] = NOP;
                else if (!stall) cur[d] = fetch(d);
            end
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && (prog0.size() > 0 || prog1.size() > 0); k++) step(1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b1);
    endtask

    initial begin
        exp_t e;
        obs_t o;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.dut == 1'b0)
                    o = '{bus0.pc_sel, bus0.pc_write, bus0.if_id_write, bus0.if_id_flush, bus0.forward_a,
                          bus0.forward_b, bus0.alu_src_ex, bus0.alu_ctrl_ex, bus0.mem_write_mem,
                          bus0.reg_write_wb, bus0.mem_to_reg_wb, bus0.rd_wb};
                else
                    o = '{bus1.pc_sel, bus1.pc_write, bus1.if_id_write, bus1.if_id_flush, bus1.forward_a,
                          bus1.forward_b, bus1.alu_src_ex, bus1.alu_ctrl_ex, bus1.mem_write_mem,
                          bus1.reg_write_wb, bus1.mem_to_reg_wb, bus1.rd_wb};
                chk("pc_sel", e.dut, 8'(o.pc_sel), 8'(e.pc_sel));
                chk("pc_write", e.dut, 8'(o.pc_write), 8'(e.pc_write));
                chk("if_id_write", e.dut, 8'(o.if_id_write), 8'(e.if_id_write));
                chk("if_id_flush", e.dut, 8'(o.flush), 8'(e.flush));
                if (e.chk_fa) chk("forward_a", e.dut, 8'(o.fa), 8'(e.fa));
                if (e.chk_fb) chk("forward_b", e.dut, 8'(o.fb), 8'(e.fb));
                chk("alu_src_ex", e.dut, 8'(o.alu_src), 8'(e.alu_src));
                chk("alu_ctrl_ex", e.dut, 8'(o.alu_ctrl), 8'(e.alu_ctrl));
                chk("mem_write_mem", e.dut, 8'(o.mem_write), 8'(e.mem_write));
                chk("reg_write_wb", e.dut, 8'(o.rw), 8'(e.rw));
                chk("mem_to_reg_wb", e.dut, 8'(o.m2r), 8'(e.m2r));
                if (e.chk_rd) chk("rd_wb", e.dut, 8'(o.rd), 8'(e.rd));
            end
        end
    end

    initial begin
        bit found;
        cur[0] = NOP; cur[1] = NOP;
        for (int d = 0; d < 2; d++) begin h_ex[d] = '0; h_mem[d] = '0; h_wb[d] = '0; end
        bus0.inst_id = NOP; bus1.inst_id = NOP;
        bus0.zero = 0; bus0.less_signed = 0; bus0.less_unsigned = 0;
        bus1.zero = 0; bus1.less_signed = 0; bus1.less_unsigned = 0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);

        load(32'h002081B3);
        drain();
        load(32'h002081B3); load(32'h401183B3);
        drain();
        load(32'h0000A283); load(32'h00528333);
        drain();
        fz = 1'b1;
        load(32'h00000463); load(32'h002081B3); load(32'h00A00193);
        drain();
        fz = 1'b0;
        load(32'h00000463); load(32'h002081B3); load(32'h00A00193);
        drain();

        load(32'h0000A283); load(32'h00528333);
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (!found && model_stall(decode(cur[0]), h_ex[0], h_mem[0], 1'b1)) begin
                step(1'b1, 1'b1);
                found = 1'b1;
            end else begin
                step(1'b0, 1'b1);
            end
        end
        n_chk++;
        if (found) n_pass++;
        else $display("FAIL reset_during_stall: actual no stall seen, required one stall cycle");
        drain();

        rand_mode = 1'b1;
        for (int k = 0; k < 600; k++) step($urandom_range(0, 63) == 0, 1'b1);
        rand_mode = 1'b0;
        fz = 0; fls = 0; flu = 0;
        drain();

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
